// File: rtl/writeline_avalon_burst.sv
// ---------------------------------------------------------------------------
// writeline_avalon_burst
//
// Consumes one 128-bit cache-line write from the writeline link stage and
// emits it as a 4-beat Avalon-MM write burst of 32-bit words. Only one line
// is in flight at a time. After each line, writeline_do is ignored for
// HOLDOFF idle cycles so the link's one-cycle-late reaction to done cannot
// start a second, unintended burst.
//
// Ports:
//   clk                clock
//   rst                synchronous reset, active-high
//   writeline_do       line write request, held high by the link until done
//   writeline_done     one-cycle pulse once the last beat has been accepted
//   writeline_address  line byte address (bits [3:0] ignored)
//   writeline_line     line data, word k = bits [32k+31:32k]
//   busy               high from the accept cycle to the done pulse inclusive
//   avm_address        Avalon word address (byte address [31:2])
//   avm_write          Avalon write strobe
//   avm_writedata      current beat data
//   avm_byteenable     constant 4'hF
//   avm_burstcount     constant 3'd4
//   avm_waitrequest    Avalon slave stall
// ---------------------------------------------------------------------------
module writeline_avalon_burst #(
   parameter int HOLDOFF = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         writeline_do,
   output logic         writeline_done,
   input  logic [31:0]  writeline_address,
   input  logic [127:0] writeline_line,
   output logic         busy,
   output logic [29:0]  avm_address,
   output logic         avm_write,
   output logic [31:0]  avm_writedata,
   output logic [3:0]   avm_byteenable,
   output logic [2:0]   avm_burstcount,
   input  logic         avm_waitrequest
);

   localparam int HoldWidth = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      DONE
   } stateT;

   stateT                 state;
   stateT                 nextState;
   logic [1:0]            beat;
   logic [1:0]            nextBeat;
   logic [HoldWidth-1:0]  holdoffCount;
   logic [127:0]          lineReg;
   logic                  acceptReq;
   logic                  beatDone;
   logic                  lastBeat;
   logic [3:0]            unusedAddrBits;

   // The line is always 16-byte aligned, so the low address nibble carries
   // no information and is deliberately dropped.
   assign unusedAddrBits = writeline_address[3:0];

   // Every burst is a full line of four whole words.
   assign avm_byteenable = 4'hF;
   assign avm_burstcount = 3'd4;

   // A request is only taken in IDLE once the holdoff window has expired.
   // A beat is accepted by the slave when we strobe write and it does not
   // stall; the burst ends on the acceptance of the fourth beat.
   assign acceptReq = (state == IDLE) && (holdoffCount == '0) && writeline_do;
   assign beatDone  = (state == BURST) && avm_write && !avm_waitrequest;
   assign lastBeat  = beatDone && (beat == 2'd3);
   assign nextBeat  = beat + 2'd1;

   // State register: reset always returns to IDLE, abandoning any partial
   // burst since the slave is reset alongside us.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: IDLE waits for an accepted request, BURST runs until
   // the fourth beat is taken, DONE lasts exactly one cycle for the pulse.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (acceptReq) nextState = BURST;
         BURST:   if (lastBeat)  nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Datapath and registered outputs. The request is captured once at
   // accept; the address stays at the burst base for all beats, and the
   // write data only advances when the slave has taken the current beat so
   // everything holds steady under back-pressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         writeline_done <= 1'b0;
         busy           <= 1'b0;
         avm_write      <= 1'b0;
         avm_address    <= '0;
         avm_writedata  <= '0;
         beat           <= '0;
         holdoffCount   <= '0;
         lineReg        <= '0;
      end else begin
         case (state)
            IDLE: begin
               writeline_done <= 1'b0;
               if (holdoffCount != '0) begin
                  holdoffCount <= holdoffCount - 1'b1;
               end else if (writeline_do) begin
                  lineReg       <= writeline_line;
                  avm_address   <= {writeline_address[31:4], 2'b00};
                  avm_writedata <= writeline_line[31:0];
                  beat          <= 2'd0;
                  avm_write     <= 1'b1;
                  busy          <= 1'b1;
               end
            end
            BURST: begin
               if (beatDone) begin
                  if (beat == 2'd3) begin
                     avm_write      <= 1'b0;
                     writeline_done <= 1'b1;
                     holdoffCount   <= HoldWidth'(HOLDOFF);
                  end else begin
                     beat          <= nextBeat;
                     avm_writedata <= lineReg[32*nextBeat +: 32];
                  end
               end
            end
            DONE: begin
               writeline_done <= 1'b0;
               busy           <= 1'b0;
            end
            default: begin
               writeline_done <= 1'b0;
               busy           <= 1'b0;
               avm_write      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_writeline_avalon_burst.sv
// ---------------------------------------------------------------------------
// tb_writeline_avalon_burst
//
// Directed bench for writeline_avalon_burst with HOLDOFF = 1. Inputs change
// 1 time unit after each rising edge and outputs are sampled at that same
// point, so every value seen reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_writeline_avalon_burst;

   logic         clk;
   logic         rst;
   logic         writeline_do;
   logic         writeline_done;
   logic [31:0]  writeline_address;
   logic [127:0] writeline_line;
   logic         busy;
   logic [29:0]  avm_address;
   logic         avm_write;
   logic [31:0]  avm_writedata;
   logic [3:0]   avm_byteenable;
   logic [2:0]   avm_burstcount;
   logic         avm_waitrequest;

   int passCount;
   int checkCount;

   localparam logic [127:0] LineA = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
   logic [31:0] words [4];

   writeline_avalon_burst #(.HOLDOFF(1)) dut (
      .clk               (clk),
      .rst               (rst),
      .writeline_do      (writeline_do),
      .writeline_done    (writeline_done),
      .writeline_address (writeline_address),
      .writeline_line    (writeline_line),
      .busy              (busy),
      .avm_address       (avm_address),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_byteenable    (avm_byteenable),
      .avm_burstcount    (avm_burstcount),
      .avm_waitrequest   (avm_waitrequest)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop so a stuck design can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive request and stall inputs, then advance one clock edge.
   task automatic applyStimulus(input logic doVal, input logic waitVal);
      writeline_do    = doVal;
      avm_waitrequest = waitVal;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst               = 1'b1;
      writeline_address = 32'h0001_2348;
      writeline_line    = LineA;
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkCount++; if (writeline_done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", writeline_done); else passCount++;
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
      checkCount++; if (avm_write !== 1'b0) $display("[TB] FAIL reset_write: got %b expected 0", avm_write); else passCount++;
      checkCount++; if (avm_address !== 30'h0) $display("[TB] FAIL reset_address: got %h expected 0", avm_address); else passCount++;
      checkCount++; if (avm_writedata !== 32'h0) $display("[TB] FAIL reset_writedata: got %h expected 0", avm_writedata); else passCount++;
      checkCount++; if (avm_byteenable !== 4'hF) $display("[TB] FAIL byteenable: got %h expected f", avm_byteenable); else passCount++;
      checkCount++; if (avm_burstcount !== 3'd4) $display("[TB] FAIL burstcount: got %0d expected 4", avm_burstcount); else passCount++;
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0);
      checkCount++; if (avm_write !== 1'b0) $display("[TB] FAIL reset_no_capture: got %b expected 0", avm_write); else passCount++;
   endtask

   task automatic test_single_burst();
      writeline_address = 32'h0001_2348;
      writeline_line    = LineA;
      applyStimulus(1'b1, 1'b0);
      checkCount++; if (avm_write !== 1'b1) $display("[TB] FAIL single_write: got %b expected 1", avm_write); else passCount++;
      checkCount++; if (busy !== 1'b1) $display("[TB] FAIL single_busy: got %b expected 1", busy); else passCount++;
      checkCount++; if (avm_writedata !== words[0]) $display("[TB] FAIL single_beat0: got %h expected %h", avm_writedata, words[0]); else passCount++;
      checkCount++; if (avm_address !== 30'h0000_48D0) $display("[TB] FAIL single_addr0: got %h expected 000048d0", avm_address); else passCount++;
      for (int k = 1; k < 4; k++) begin
         applyStimulus(1'b1, 1'b0);
         checkCount++; if (avm_writedata !== words[k]) $display("[TB] FAIL single_beat%0d: got %h expected %h", k, avm_writedata, words[k]); else passCount++;
         checkCount++; if (avm_address !== 30'h0000_48D0) $display("[TB] FAIL single_addr%0d: got %h expected 000048d0", k, avm_address); else passCount++;
         checkCount++; if (writeline_done !== 1'b0) $display("[TB] FAIL single_early_done%0d: got %b expected 0", k, writeline_done); else passCount++;
      end
      applyStimulus(1'b1, 1'b0);
      checkCount++; if (writeline_done !== 1'b1) $display("[TB] FAIL single_done: got %b expected 1", writeline_done); else passCount++;
      checkCount++; if (avm_write !== 1'b0) $display("[TB] FAIL single_write_end: got %b expected 0", avm_write); else passCount++;
      checkCount++; if (busy !== 1'b1) $display("[TB] FAIL single_busy_done: got %b expected 1", busy); else passCount++;
      applyStimulus(1'b0, 1'b0);
      checkCount++; if (writeline_done !== 1'b0) $display("[TB] FAIL single_done_width: got %b expected 0", writeline_done); else passCount++;
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL single_busy_idle: got %b expected 0", busy); else passCount++;
      applyStimulus(1'b0, 1'b0);
   endtask

   task automatic test_stall();
      writeline_address = 32'h0001_2348;
      writeline_line    = LineA;
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkCount++; if (avm_writedata !== words[2]) $display("[TB] FAIL stall_beat2: got %h expected %h", avm_writedata, words[2]); else passCount++;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b1);
         checkCount++; if (avm_writedata !== words[2]) $display("[TB] FAIL stall_hold_data%0d: got %h expected %h", k, avm_writedata, words[2]); else passCount++;
         checkCount++; if (avm_write !== 1'b1) $display("[TB] FAIL stall_hold_write%0d: got %b expected 1", k, avm_write); else passCount++;
      end
      applyStimulus(1'b1, 1'b0);
      checkCount++; if (avm_writedata !== words[3]) $display("[TB] FAIL stall_beat3: got %h expected %h", avm_writedata, words[3]); else passCount++;
      checkCount++; if (writeline_done !== 1'b0) $display("[TB] FAIL stall_early_done: got %b expected 0", writeline_done); else passCount++;
      applyStimulus(1'b1, 1'b0);
      checkCount++; if (writeline_done !== 1'b1) $display("[TB] FAIL stall_done: got %b expected 1", writeline_done); else passCount++;
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
   endtask

   task automatic test_holdoff();
      writeline_address = 32'h0001_2348;
      writeline_line    = LineA;
      applyStimulus(1'b1, 1'b0);
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0);
      checkCount++; if (writeline_done !== 1'b1) $display("[TB] FAIL holdoff_done: got %b expected 1", writeline_done); else passCount++;
      writeline_address = 32'h0000_0010;
      applyStimulus(1'b1, 1'b0);
      checkCount++; if (avm_write !== 1'b0) $display("[TB] FAIL holdoff_done_cycle_write: got %b expected 0", avm_write); else passCount++;
      applyStimulus(1'b1, 1'b0);
      checkCount++; if (avm_write !== 1'b0) $display("[TB] FAIL holdoff_ignored_write: got %b expected 0", avm_write); else passCount++;
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL holdoff_ignored_busy: got %b expected 0", busy); else passCount++;
      applyStimulus(1'b0, 1'b0);
      checkCount++; if (avm_write !== 1'b0) $display("[TB] FAIL holdoff_idle_write: got %b expected 0", avm_write); else passCount++;
      applyStimulus(1'b1, 1'b0);
      checkCount++; if (avm_write !== 1'b1) $display("[TB] FAIL holdoff_second_write: got %b expected 1", avm_write); else passCount++;
      checkCount++; if (avm_address !== 30'h4) $display("[TB] FAIL holdoff_second_addr: got %h expected 00000004", avm_address); else passCount++;
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0);
      checkCount++; if (writeline_done !== 1'b1) $display("[TB] FAIL holdoff_second_done: got %b expected 1", writeline_done); else passCount++;
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
   endtask

   task automatic test_line_change();
      writeline_address = 32'h0001_2348;
      writeline_line    = LineA;
      applyStimulus(1'b1, 1'b0);
      writeline_line    = 128'h0;
      writeline_address = 32'hFFFF_FFF0;
      for (int k = 1; k < 4; k++) begin
         applyStimulus(1'b1, 1'b0);
         checkCount++; if (avm_writedata !== words[k]) $display("[TB] FAIL change_beat%0d: got %h expected %h", k, avm_writedata, words[k]); else passCount++;
         checkCount++; if (avm_address !== 30'h0000_48D0) $display("[TB] FAIL change_addr%0d: got %h expected 000048d0", k, avm_address); else passCount++;
      end
      applyStimulus(1'b1, 1'b0);
      checkCount++; if (writeline_done !== 1'b1) $display("[TB] FAIL change_done: got %b expected 1", writeline_done); else passCount++;
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_burst();
      bit doneSeen;
      int doneAt;
      writeline_address = 32'h0001_2348;
      writeline_line    = LineA;
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkCount++; if (avm_writedata !== words[1]) $display("[TB] FAIL midreset_beat1: got %h expected %h", avm_writedata, words[1]); else passCount++;
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0);
      checkCount++; if (avm_write !== 1'b0) $display("[TB] FAIL midreset_write: got %b expected 0", avm_write); else passCount++;
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b expected 0", busy); else passCount++;
      rst = 1'b0;
      doneSeen = (writeline_done === 1'b1);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b0, 1'b0);
         if (writeline_done === 1'b1) doneSeen = 1'b1;
      end
      checkCount++; if (doneSeen !== 1'b0) $display("[TB] FAIL midreset_no_done: got %b expected 0", doneSeen); else passCount++;
      writeline_address = 32'h0000_0010;
      applyStimulus(1'b1, 1'b0);
      checkCount++; if (avm_address !== 30'h4) $display("[TB] FAIL midreset_new_addr: got %h expected 00000004", avm_address); else passCount++;
      doneAt = -1;
      for (int k = 1; k <= 10 && doneAt < 0; k++) begin
         applyStimulus(1'b1, 1'b0);
         if (writeline_done === 1'b1) doneAt = k;
      end
      checkCount++; if (doneAt !== 4) $display("[TB] FAIL midreset_new_done_latency: got %0d expected 4", doneAt); else passCount++;
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
   endtask

   task automatic test_toggle_wait();
      logic [31:0] got [8];
      int nBeats;
      int doneCount;
      int afterDone;
      logic waitVal;
      logic doVal;
      nBeats    = 0;
      doneCount = 0;
      afterDone = -1;
      writeline_address = 32'h0001_2348;
      writeline_line    = LineA;
      applyStimulus(1'b1, 1'b0);
      doVal = 1'b1;
      for (int cyc = 0; cyc < 40 && afterDone < 3; cyc++) begin
         waitVal = (cyc % 2 == 0);
         if (avm_write === 1'b1 && !waitVal && nBeats < 8) begin
            got[nBeats] = avm_writedata;
            nBeats++;
         end
         applyStimulus(doVal, waitVal);
         if (writeline_done === 1'b1) begin
            doneCount++;
            doVal = 1'b0;
         end
         if (doneCount > 0) afterDone++;
      end
      checkCount++; if (nBeats !== 4) $display("[TB] FAIL toggle_beats: got %0d expected 4", nBeats); else passCount++;
      for (int k = 0; k < 4; k++) begin
         checkCount++; if (got[k] !== words[k]) $display("[TB] FAIL toggle_word%0d: got %h expected %h", k, got[k], words[k]); else passCount++;
      end
      checkCount++; if (doneCount !== 1) $display("[TB] FAIL toggle_done_count: got %0d expected 1", doneCount); else passCount++;
   endtask

   initial begin
      passCount       = 0;
      checkCount      = 0;
      words[0]        = 32'hAAAA_AAAA;
      words[1]        = 32'hBBBB_BBBB;
      words[2]        = 32'hCCCC_CCCC;
      words[3]        = 32'hDDDD_DDDD;
      rst             = 1'b1;
      writeline_do    = 1'b0;
      avm_waitrequest = 1'b0;
      writeline_address = '0;
      writeline_line    = '0;
      test_reset();
      test_single_burst();
      test_stall();
      test_holdoff();
      test_line_change();
      test_reset_mid_burst();
      test_toggle_wait();
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
